// File: rtl/msgPass_config_pkg.sv
// Shared message-passing buffer configuration plus the write-scheduler types.
// Buffer widths live here so every block sees one definition.
package msgPass_config_pkg;

  localparam int MSGPASS_BUFF_ADDR_WIDTH  = 8;
  localparam int MSGPASS_BUFF_RDATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } msgpass_wr_sched_state_e;

  typedef struct packed {
    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  addr;
    logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] data;
  } msgpass_wr_req_t;

endpackage

// File: rtl/msgpass_wr_fifo.sv
// Per-requester write-request FIFO; head is visible combinationally.
// Pointers carry one extra MSB so full and empty can be told apart.
module msgpass_wr_fifo
  import msgPass_config_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic            sys_clk_i,
  input  logic            rstn,
  input  logic            push,
  input  msgpass_wr_req_t push_req,
  input  logic            pop,
  output msgpass_wr_req_t head,
  output logic            full,
  output logic            empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  msgpass_wr_req_t mem [FIFO_DEPTH];

  always_ff @(posedge sys_clk_i or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_req;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/msgpass_wr_sched.sv
// Two-requester write scheduler for the dual-port message buffer, with flush/drain.
// Optional MSGPASS_WR_CONFLICT_CNT_EN adds a saturating same-address deferral counter.
module msgpass_wr_sched
  import msgPass_config_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                sys_clk_i,
  input  logic                                rstn,
  input  logic                                req_valid_a_i,
  input  logic                                req_valid_b_i,
  output logic                                req_ready_a_o,
  output logic                                req_ready_b_o,
  input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  req_addr_a_i,
  input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  req_addr_b_i,
  input  logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] req_data_a_i,
  input  logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] req_data_b_i,
  output logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  waddr_portA_o,
  output logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  waddr_portB_o,
  output logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] wdata_portA_o,
  output logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] wdata_portB_o,
  output logic                                wen_portA_o,
  output logic                                wen_portB_o,
  input  logic                                buf_conflict_i,
  input  logic                                flush_i,
  output logic                                flush_done_o,
  output logic                                err_conflict_o
`ifdef MSGPASS_WR_CONFLICT_CNT_EN
  ,
  output logic [15:0]                         conflict_cnt_o
`endif
);

  msgpass_wr_sched_state_e state;
  msgpass_wr_req_t         head_a, head_b;
  logic full_a, full_b, empty_a, empty_b;
  logic push_a, push_b;
  logic issue_a, issue_b, same_addr;
  logic prio_b;
  logic ready_en;
  logic accept_ok;
  logic both_empty;

  // ready_en keeps ready low until the first edge after reset release
  assign accept_ok     = ready_en && (state == ST_IDLE || state == ST_ACTIVE);
  assign req_ready_a_o = accept_ok && !full_a;
  assign req_ready_b_o = accept_ok && !full_b;
  assign push_a        = req_valid_a_i && req_ready_a_o;
  assign push_b        = req_valid_b_i && req_ready_b_o;
  assign both_empty    = empty_a && empty_b;

  msgpass_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo_a (
    .sys_clk_i (sys_clk_i),
    .rstn      (rstn),
    .push      (push_a),
    .push_req  ('{addr: req_addr_a_i, data: req_data_a_i}),
    .pop       (issue_a),
    .head      (head_a),
    .full      (full_a),
    .empty     (empty_a)
  );

  msgpass_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo_b (
    .sys_clk_i (sys_clk_i),
    .rstn      (rstn),
    .push      (push_b),
    .push_req  ('{addr: req_addr_b_i, data: req_data_b_i}),
    .pop       (issue_b),
    .head      (head_b),
    .full      (full_b),
    .empty     (empty_b)
  );

  // Equal-address heads: only the priority side issues, the other head is held
  always_comb begin
    same_addr = !empty_a && !empty_b && (head_a.addr == head_b.addr);
    issue_a   = !empty_a && !(same_addr && prio_b);
    issue_b   = !empty_b && !(same_addr && !prio_b);
  end

  always_ff @(posedge sys_clk_i or negedge rstn) begin
    if (!rstn) begin
      wen_portA_o    <= 1'b1;
      wen_portB_o    <= 1'b1;
      waddr_portA_o  <= '0;
      waddr_portB_o  <= '0;
      wdata_portA_o  <= '0;
      wdata_portB_o  <= '0;
      prio_b         <= 1'b0;
      err_conflict_o <= 1'b0;
    end else begin
      wen_portA_o <= !issue_a;
      wen_portB_o <= !issue_b;
      if (issue_a) begin
        waddr_portA_o <= head_a.addr;
        wdata_portA_o <= head_a.data;
      end
      if (issue_b) begin
        waddr_portB_o <= head_b.addr;
        wdata_portB_o <= head_b.data;
      end
      if (same_addr)      prio_b         <= !prio_b;
      if (buf_conflict_i) err_conflict_o <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      flush_done_o <= 1'b0;
      ready_en     <= 1'b0;
    end else begin
      ready_en     <= 1'b1;
      flush_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush_i)          state <= ST_DRAIN;
          else if (!both_empty) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (flush_i)         state <= ST_DRAIN;
          else if (both_empty) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          // drained once nothing is queued and the output register is idle
          if (both_empty && wen_portA_o && wen_portB_o) begin
            state        <= ST_DONE;
            flush_done_o <= 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef MSGPASS_WR_CONFLICT_CNT_EN
  always_ff @(posedge sys_clk_i or negedge rstn) begin
    if (!rstn) begin
      conflict_cnt_o <= '0;
    end else if (same_addr && conflict_cnt_o != '1) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end
`endif

endmodule
